// File: rtl/session_controller.sv
`default_nettype none
// ============================================================================
// Module      : session_controller
// Description : Access-control sequencer for the number-matching game: drives
//               the password checker, counts failures, enforces lockout and
//               grants the adder datapath. Optional macro SESSION_TIMEOUT_EN
//               adds an inactivity timeout in GRANT.
// Revision    : 1.0 - initial release
// ============================================================================
module session_controller #(
    parameter int MAX_FAILS      = 3,
    parameter int FAIL_W         = 2,
    parameter int LOCK_CYCLES    = 1000,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rts,
    input  logic              enter,
    input  logic              auth_done,
    input  logic              auth_pass,
    input  logic              logout,
    output logic              auth_en,
    output logic              auth_clr,
    output logic              adder_en,
    output logic              adder_dis,
    output logic              locked,
    output logic [FAIL_W-1:0] fail_cnt,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_AUTH  = 2'b01,
        S_GRANT = 2'b10,
        S_LOCK  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0]  c_lock_load    = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0]  c_timeout_load = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FAIL_W-1:0] c_fail_max     = FAIL_W'(MAX_FAILS);
    localparam logic [FAIL_W:0]   c_fail_limit   = (FAIL_W+1)'(MAX_FAILS);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [FAIL_W:0]   w_fail_next;

    // One extra bit so the compare against MAX_FAILS cannot wrap.
    assign w_fail_next = {1'b0, fail_cnt} + (FAIL_W+1)'(1);
    assign state_dbg   = r_state;

`ifndef SESSION_TIMEOUT_EN
    logic w_unused_enter;
    assign w_unused_enter = enter;
`endif

    always_ff @(negedge clk or negedge rts) begin
        if (!rts) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            auth_en   <= 1'b0;
            auth_clr  <= 1'b0;
            adder_en  <= 1'b0;
            adder_dis <= 1'b1;
            locked    <= 1'b0;
            fail_cnt  <= '0;
        end else begin
            auth_clr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_state  <= S_AUTH;
                    auth_en  <= 1'b1;
                    auth_clr <= 1'b1;
                    r_cnt    <= '0;
                end
                S_AUTH: begin
                    if (auth_done) begin
                        if (auth_pass) begin
                            r_state   <= S_GRANT;
                            auth_en   <= 1'b0;
                            adder_en  <= 1'b1;
                            adder_dis <= 1'b0;
                            fail_cnt  <= '0;
                            r_cnt     <= c_timeout_load;
                        end else if (w_fail_next < c_fail_limit) begin
                            fail_cnt <= w_fail_next[FAIL_W-1:0];
                            auth_clr <= 1'b1;
                        end else begin
                            r_state  <= S_LOCK;
                            auth_en  <= 1'b0;
                            locked   <= 1'b1;
                            fail_cnt <= c_fail_max;
                            r_cnt    <= c_lock_load;
                        end
                    end
                end
                S_LOCK: begin
                    if (r_cnt == '0) begin
                        r_state  <= S_IDLE;
                        locked   <= 1'b0;
                        fail_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_GRANT: begin
`ifdef SESSION_TIMEOUT_EN
                    // enter on the expiry cycle keeps the session; logout always ends it.
                    if (logout || (!enter && r_cnt == '0)) begin
                        r_state   <= S_IDLE;
                        adder_en  <= 1'b0;
                        adder_dis <= 1'b1;
                        r_cnt     <= '0;
                    end else if (enter) begin
                        r_cnt <= c_timeout_load;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
`else
                    if (logout) begin
                        r_state   <= S_IDLE;
                        adder_en  <= 1'b0;
                        adder_dis <= 1'b1;
                        r_cnt     <= '0;
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
